// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_if : fetch-side push and decode-side pop signals of fetch_queue
// Revision 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] instr_f;
    logic [WIDTH-1:0] pc_plus_4_f;
    logic             valid_f;
    logic             ready_f;
    logic             stall_d;
    logic             flush;
    logic [WIDTH-1:0] instr_d;
    logic [WIDTH-1:0] pc_plus_4_d;
    logic             valid_d;
    logic [CW-1:0]    count;

    // The queue itself is the slave; fetch, hazard unit and decode are the master.
    modport slave (
        input  instr_f, pc_plus_4_f, valid_f, stall_d, flush,
        output ready_f, instr_d, pc_plus_4_d, valid_d, count
    );

    modport master (
        output instr_f, pc_plus_4_f, valid_f, stall_d, flush,
        input  ready_f, instr_d, pc_plus_4_d, valid_d, count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : show-ahead circular prefetch FIFO between fetch and decode
// Revision 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire            clk,
    input  wire            rst_n,
    fetch_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] mem_instr_q [DEPTH];
    logic [WIDTH-1:0] mem_pc_q    [DEPTH];

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Status comes from registered state only, so a same-cycle pop never frees a slot.
    assign w_ready = (count_q < CW'(DEPTH));
    assign w_valid = (count_q != '0);
    assign w_push  = bus.valid_f & w_ready & ~bus.flush;
    assign w_pop   = w_valid & ~bus.stall_d & ~bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (w_push && !w_pop)      count_d = count_q + CW'(1);
            else if (!w_push && w_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only observable through count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr_q[wr_ptr_q] <= bus.instr_f;
            mem_pc_q[wr_ptr_q]    <= bus.pc_plus_4_f;
        end
    end

    assign bus.ready_f     = w_ready;
    assign bus.valid_d     = w_valid;
    assign bus.count       = count_q;
    assign bus.instr_d     = w_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign bus.pc_plus_4_d = w_valid ? mem_pc_q[rd_ptr_q]    : '0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue
// Revision 1.0
// ============================================================================
module tb_fetch_queue;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_queue_if #(.DEPTH(4), .WIDTH(32)) bus ();

    fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.valid_f     = 1'b0;
        bus.stall_d     = 1'b0;
        bus.flush       = 1'b0;
        bus.instr_f     = 32'h0;
        bus.pc_plus_4_f = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.valid_d); end
        checks++; if (bus.ready_f !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.ready_f); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.instr_d !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", bus.instr_d); end
        checks++; if (bus.pc_plus_4_d !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.pc_plus_4_d); end
    endtask

    task automatic test_fill();
        logic [31:0] ins [4];
        ins[0] = 32'h20080001; ins[1] = 32'h20090002; ins[2] = 32'h200A0003; ins[3] = 32'h200B0004;
        bus.stall_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.valid_f     = 1'b1;
            bus.instr_f     = ins[i];
            bus.pc_plus_4_f = 32'(4 * (i + 1));
            step();
            checks++; if (bus.instr_d !== 32'h20080001) begin errors++; $display("FAIL fill_head%0d got %h exp 20080001", i, bus.instr_d); end
            checks++; if (bus.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", i, bus.count, i + 1); end
        end
        checks++; if (bus.ready_f !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", bus.ready_f); end
        bus.instr_f     = 32'hDEADBEEF;
        bus.pc_plus_4_f = 32'd20;
        step();
        bus.valid_f = 1'b0;
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fifth_ignored got %0d exp 4", bus.count); end
        checks++; if (bus.instr_d !== 32'h20080001) begin errors++; $display("FAIL full_head got %h exp 20080001", bus.instr_d); end
        checks++; if (bus.pc_plus_4_d !== 32'd4) begin errors++; $display("FAIL full_pc got %0d exp 4", bus.pc_plus_4_d); end
    endtask

    task automatic test_drain();
        logic [31:0] ins [4];
        ins[0] = 32'h20080001; ins[1] = 32'h20090002; ins[2] = 32'h200A0003; ins[3] = 32'h200B0004;
        bus.valid_f = 1'b0;
        bus.stall_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.instr_d !== ins[i]) begin errors++; $display("FAIL drain_instr%0d got %h exp %h", i, bus.instr_d, ins[i]); end
            checks++; if (bus.pc_plus_4_d !== 32'(4 * (i + 1))) begin errors++; $display("FAIL drain_pc%0d got %0d exp %0d", i, bus.pc_plus_4_d, 4 * (i + 1)); end
            step();
        end
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", bus.valid_d); end
        checks++; if (bus.instr_d !== 32'h0) begin errors++; $display("FAIL drain_instr_nop got %h exp 0", bus.instr_d); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_stream_wrap();
        bus.stall_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.valid_f     = 1'b1;
            bus.instr_f     = 32'h10000000 + 32'(k);
            bus.pc_plus_4_f = 32'h100 + 32'(4 * k);
            step();
            checks++; if (bus.instr_d !== 32'h10000000 + 32'(k)) begin errors++; $display("FAIL stream_instr%0d got %h exp %h", k, bus.instr_d, 32'h10000000 + 32'(k)); end
            checks++; if (bus.pc_plus_4_d !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got %h exp %h", k, bus.pc_plus_4_d, 32'h100 + 32'(4 * k)); end
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL stream_count%0d got %0d exp 1", k, bus.count); end
        end
        bus.valid_f = 1'b0;
        step();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_full_pop_no_push();
        bus.stall_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.valid_f = 1'b1;
            bus.instr_f = 32'hA0 + 32'(i);
            step();
        end
        bus.stall_d = 1'b0;
        bus.instr_f = 32'hEEEE0000;
        step();
        bus.valid_f = 1'b0;
        bus.stall_d = 1'b1;
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d exp 3", bus.count); end
        checks++; if (bus.instr_d !== 32'hA1) begin errors++; $display("FAIL fullpop_head got %h exp a1", bus.instr_d); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_stalled_count got %0d exp 0", bus.count); end
        checks++; if (bus.ready_f !== 1'b1) begin errors++; $display("FAIL flush_stalled_ready got %0b exp 1", bus.ready_f); end
    endtask

    task automatic test_flush();
        bus.stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.valid_f = 1'b1;
            bus.instr_f = 32'hB0 + 32'(i);
            step();
        end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL preflush_count got %0d exp 3", bus.count); end
        bus.stall_d = 1'b0;
        bus.flush   = 1'b1;
        bus.instr_f = 32'hBADBAD00;
        step();
        bus.flush   = 1'b0;
        bus.valid_f = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", bus.valid_d); end
        step();
        checks++; if (bus.instr_d === 32'hBADBAD00 || bus.valid_d !== 1'b0) begin errors++; $display("FAIL flush_leak got %h valid %0b exp 0", bus.instr_d, bus.valid_d); end
    endtask

    task automatic test_async_reset();
        bus.stall_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.valid_f = 1'b1;
            bus.instr_f = 32'hC0 + 32'(i);
            step();
        end
        bus.valid_f = 1'b0;
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL prereset_count got %0d exp 2", bus.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_d !== 1'b0) begin errors++; $display("FAIL async_valid got %0b exp 0", bus.valid_d); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL async_count got %0d exp 0", bus.count); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (bus.ready_f !== 1'b1) begin errors++; $display("FAIL postreset_ready got %0b exp 1", bus.ready_f); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        idle();
        test_full_pop_no_push();
        idle();
        test_flush();
        idle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
